// File: rtl/prng_range.sv
// prng_range: Fibonacci LFSR pseudo-random generator with a req/valid
// interface that returns unbiased values in [0, limit) by rejection sampling.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   seed_load  load seed into the LFSR this cycle (zero seed -> SEED_DEFAULT)
//   seed       seed value
//   step_en    advance the LFSR one step per cycle while idle
//   req        request a bounded draw (accepted when req & ready)
//   limit      exclusive upper bound of the draw; 0 selects the full range
//   ready      high while idle
//   valid      one-cycle pulse when rand_out has been updated
//   rand_out   last drawn value, held until the next valid
//   state_out  current LFSR state
module prng_range #(
  parameter int unsigned          WIDTH        = 16,
  parameter logic [WIDTH-1:0]     TAPS         = WIDTH'(16'hB400),
  parameter int unsigned          OUT_W        = 8,
  parameter int unsigned          MAX_TRIES    = 4,
  parameter logic [WIDTH-1:0]     SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step_en,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] state_out
);

  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [TW-1:0]    r_tries;
  logic [OUT_W-1:0] r_limit_q;
  logic [OUT_W-1:0] r_mask;
  logic             r_valid;
  logic [OUT_W-1:0] r_rand;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [TW-1:0]    w_tries_nxt;
  logic [OUT_W-1:0] w_limit_nxt;
  logic [OUT_W-1:0] w_mask_nxt;
  logic             w_valid_nxt;
  logic [OUT_W-1:0] w_rand_nxt;

  logic [WIDTH-1:0] w_step;
  logic [OUT_W-1:0] w_cand;
  logic             w_hit;
  logic             w_last;

  // Smallest 2^k-1 covering lim-1, built by smearing the top set bit down.
  // lim=0 wraps to all ones and lim=1 gives 0, which are exactly the
  // full-range and single-value cases.
  function automatic logic [OUT_W-1:0] f_mask(input logic [OUT_W-1:0] lim);
    logic [OUT_W-1:0] v;
    v = lim - OUT_W'(1);
    for (int unsigned i = 1; i < OUT_W; i++) begin
      v = v | (v >> i);
    end
    return v;
  endfunction

  assign w_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
  assign w_cand = r_lfsr[OUT_W-1:0] & r_mask;
  assign w_hit  = (r_limit_q == '0) || (w_cand < r_limit_q);
  assign w_last = (r_tries == TW'(MAX_TRIES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_limit_nxt = r_limit_q;
    w_mask_nxt  = r_mask;
    w_valid_nxt = 1'b0;
    w_rand_nxt  = r_rand;
    w_lfsr_nxt  = r_lfsr;

    case (r_state)
      IDLE: begin
        if (req) begin
          w_limit_nxt = limit;
          w_mask_nxt  = f_mask(limit);
          w_tries_nxt = '0;
          w_state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (w_hit) begin
          w_rand_nxt  = w_cand;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_last) begin
          // mask < 2*limit, so a single subtraction lands in range
          w_rand_nxt  = w_cand - r_limit_q;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tries_nxt = r_tries + TW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (seed_load) begin
      w_lfsr_nxt = (seed == '0) ? SEED_DEFAULT : seed;
    end else if (r_lfsr == '0) begin
      w_lfsr_nxt = SEED_DEFAULT;
    end else if (r_state == DRAW) begin
      w_lfsr_nxt = w_step;
    end else if (step_en) begin
      w_lfsr_nxt = w_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED_DEFAULT;
      r_tries   <= '0;
      r_limit_q <= '0;
      r_mask    <= '0;
      r_valid   <= 1'b0;
      r_rand    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_tries   <= w_tries_nxt;
      r_limit_q <= w_limit_nxt;
      r_mask    <= w_mask_nxt;
      r_valid   <= w_valid_nxt;
      r_rand    <= w_rand_nxt;
    end
  end

  assign ready     = (r_state == IDLE);
  assign valid     = r_valid;
  assign rand_out  = r_rand;
  assign state_out = r_lfsr;

endmodule

// File: tb/tb_prng_range.sv
module tb_prng_range;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load, step_en, req;
  logic [7:0] seed, limit;
  logic       ready, valid;
  logic [7:0] rand_out, state_out;

  logic       fb_seed_load, fb_step_en, fb_req;
  logic [7:0] fb_seed, fb_limit;
  logic       fb_ready, fb_valid;
  logic [7:0] fb_rand_out, fb_state_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] s;
    int         cyc;
  } item_t;

  item_t q_main[$];
  item_t q_fb[$];

  prng_range #(
    .WIDTH(8), .TAPS(8'hB8), .OUT_W(8), .MAX_TRIES(4), .SEED_DEFAULT(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .step_en(step_en), .req(req), .limit(limit), .ready(ready),
    .valid(valid), .rand_out(rand_out), .state_out(state_out)
  );

  prng_range #(
    .WIDTH(8), .TAPS(8'hB8), .OUT_W(8), .MAX_TRIES(1), .SEED_DEFAULT(8'h01)
  ) dut_fb (
    .clk(clk), .rst(rst), .seed_load(fb_seed_load), .seed(fb_seed),
    .step_en(fb_step_en), .req(fb_req), .limit(fb_limit), .ready(fb_ready),
    .valid(fb_valid), .rand_out(fb_rand_out), .state_out(fb_state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expected draw per valid pulse.
  always @(negedge clk) begin
    item_t e;
    if (valid) begin
      if (q_main.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_valid: got valid=1 expected 0 (t=%0t)", $time);
      end else begin
        e = q_main.pop_front();
        chk("main_rand", rand_out, e.r);
        chk("main_state", state_out, e.s);
        chk("main_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    item_t e;
    if (fb_valid) begin
      if (q_fb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fb_unexpected_valid: got valid=1 expected 0 (t=%0t)", $time);
      end else begin
        e = q_fb.pop_front();
        chk("fb_rand", fb_rand_out, e.r);
        chk("fb_state", fb_state_out, e.s);
        chk("fb_latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_main();
    int n = 0;
    while (q_main.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q_main.size() != 0) begin
      errors++;
      $display("FAIL main_timeout: got %0d pending expected 0", q_main.size());
      q_main.delete();
    end
  endtask

  task automatic wait_fb();
    int n = 0;
    while (q_fb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q_fb.size() != 0) begin
      errors++;
      $display("FAIL fb_timeout: got %0d pending expected 0", q_fb.size());
      q_fb.delete();
    end
  endtask

  task automatic load(input logic [7:0] s);
    seed_load = 1'b1;
    seed      = s;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask

  task automatic fb_load(input logic [7:0] s);
    fb_seed_load = 1'b1;
    fb_seed      = s;
    @(posedge clk); #1;
    fb_seed_load = 1'b0;
  endtask

  // rej = number of rejected candidates before the accepted/fallback one
  task automatic draw(input logic [7:0] lim, input logic [7:0] r,
                      input logic [7:0] s, input int rej);
    req   = 1'b1;
    limit = lim;
    @(posedge clk); #1;
    q_main.push_back('{r, s, cyc + 1 + rej});
    req = 1'b0;
    chk("busy_ready", ready, 0);
    wait_main();
  endtask

  task automatic fb_draw(input logic [7:0] lim, input logic [7:0] r,
                         input logic [7:0] s, input int rej);
    fb_req   = 1'b1;
    fb_limit = lim;
    @(posedge clk); #1;
    q_fb.push_back('{r, s, cyc + 1 + rej});
    fb_req = 1'b0;
    wait_fb();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [6];
    logic       seen_zero, early;
    int         a;
    seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

    rst = 1'b1; seed_load = 1'b0; seed = '0; step_en = 1'b0; req = 1'b0; limit = '0;
    fb_seed_load = 1'b0; fb_seed = '0; fb_step_en = 1'b0; fb_req = 1'b0; fb_limit = '0;
    #22 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset_ready", ready, 1);
    chk("reset_valid", valid, 0);
    chk("reset_rand", rand_out, 0);
    chk("reset_state", state_out, 8'h01);

    // Free-running sequence and full period
    step_en = 1'b1;
    load(8'h01);
    chk("seq_load", state_out, 8'h01);
    seen_zero = 1'b0;
    early     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("seq_step", state_out, seq[i]);
    end
    for (int i = 7; i <= 255; i++) begin
      @(posedge clk); #1;
      if (state_out == 8'h00) seen_zero = 1'b1;
      if (state_out == 8'h01 && i < 255) early = 1'b1;
    end
    step_en = 1'b0;
    chk("seq_period", state_out, 8'h01);
    chk("seq_no_zero_no_early", {seen_zero, early}, 0);

    // First-candidate accept
    load(8'h01);
    draw(8'd3, 8'd1, 8'h02, 0);

    // One rejection: cand 3 then 0x06 -> 2
    load(8'h03);
    draw(8'd3, 8'd2, 8'h0C, 1);

    // Zero seed replaced by default
    load(8'h00);
    chk("seed_zero", state_out, 8'h01);

    // limit=1 forces 0
    draw(8'd1, 8'd0, 8'h02, 0);

    // limit=0 returns raw low byte
    load(8'hA5);
    draw(8'd0, 8'hA5, 8'h4A, 0);

    // Three rejections (7,6,5), accepted on the last allowed try
    load(8'h07);
    draw(8'd5, 8'd2, 8'h75, 3);

    // Back-to-back with req held high: accepts on A, A+2, A+4
    load(8'h01);
    req   = 1'b1;
    limit = 8'd0;
    @(posedge clk); #1;
    a = cyc;
    q_main.push_back('{8'h01, 8'h02, a + 1});
    q_main.push_back('{8'h02, 8'h04, a + 3});
    q_main.push_back('{8'h04, 8'h08, a + 5});
    repeat (4) @(posedge clk);
    #1 req = 1'b0;
    wait_main();

    // Reset in the middle of a draw
    load(8'h03);
    req   = 1'b1;
    limit = 8'd3;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_valid", valid, 0);
    chk("midrst_rand", rand_out, 0);
    chk("midrst_state", state_out, 8'h01);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_state", state_out, 8'h01);
    draw(8'd3, 8'd1, 8'h02, 0);

    // Fallback reduction with MAX_TRIES=1
    fb_load(8'h07);
    fb_draw(8'd5, 8'd2, 8'h0E, 0);
    fb_draw(8'd5, 8'd1, 8'h1D, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_range.md
Name: prng_range

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator with a request/valid interface. Returns unbiased values in [0, limit) by rejection sampling.
- Successor to the fixed 8-bit free-running generator. Adds configurable width and taps, runtime seed load, zero-state protection, step enable and bounded-range draws.
- Used by game logic (event selection, mood/hunger dice rolls). The raw LFSR state is also exported.

Parameters:
- WIDTH, 16, LFSR state width (min 4).
- TAPS, 16'hB400, feedback mask. Bit i set means state[i] is XORed into the new LSB. Must describe a maximal-length polynomial.
- OUT_W, 8, width of limit and rand_out (OUT_W <= WIDTH).
- MAX_TRIES, 4, rejection attempts before the fallback reduction (>= 1).
- SEED_DEFAULT, 1, value loaded on reset and in place of an all-zero seed (nonzero).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seed_load  input  1  load seed into LFSR this cycle.
- seed  input  WIDTH  seed value.
- step_en  input  1  advance LFSR one step per cycle while IDLE.
- req  input  1  request a bounded draw.
- limit  input  OUT_W  exclusive upper bound; 0 means full range.
- ready  output  1  high in IDLE; req is accepted when req & ready.
- valid  output  1  one-cycle pulse, rand_out updated.
- rand_out  output  OUT_W  last drawn value, held until the next valid.
- state_out  output  WIDTH  current LFSR state.

Behaviour:
- Reset (async):
  - lfsr = SEED_DEFAULT; FSM = IDLE; tries = 0.
  - valid = 0; rand_out = 0; ready = 1 once rst is released.
- Step function: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- LFSR update priority:
  - seed_load is highest: lfsr = (seed == 0) ? SEED_DEFAULT : seed.
  - Else, in DRAW the LFSR advances every cycle.
  - Else, in IDLE the LFSR advances when step_en = 1.
  - Otherwise the LFSR holds.
- Zero guard: if lfsr ever reads 0 (e.g. SEU), the next state is SEED_DEFAULT regardless of step_en.
- FSM states: IDLE and DRAW.
- IDLE:
  - ready = 1.
  - On req: latch limit_q = limit, compute mask, set tries = 0, go to DRAW. The LFSR does not advance on the accept edge unless step_en is high.
  - req while ready = 0 is ignored (not queued).
- Mask:
  - limit_q = 0: all ones.
  - limit_q = 1: 0.
  - Otherwise: smallest 2^k - 1 >= limit_q - 1.
- DRAW, each cycle, with cand = lfsr[OUT_W-1:0] & mask:
  - If limit_q == 0 or cand < limit_q: rand_out <= cand, valid <= 1, go to IDLE.
  - Else if tries == MAX_TRIES-1: rand_out <= cand - limit_q (always < limit_q because mask < 2*limit_q), valid <= 1, go to IDLE.
  - Else: tries++, stay in DRAW.
- Latency: valid rises 2 cycles after the accept edge when the first candidate is accepted, plus 1 cycle per rejection. Worst case is MAX_TRIES+1 cycles.
- Back-to-back draws: ready is already 1 in the valid cycle, so a new req can be accepted in that cycle.
- valid is registered and lasts exactly 1 cycle.
- seed_load during DRAW: the draw is not aborted; it continues from the loaded value on the next cycle.
- Reset mid-DRAW: returns to IDLE immediately and no valid is emitted.

Test Plan:
- Sequence (WIDTH=8, TAPS=8'hB8, seed_load 0x01, step_en=1): state_out = 0x02, 0x04, 0x08, 0x11, 0x23, 0x47 on successive cycles. After 255 steps it returns to 0x01 and never shows 0.
- Single accept (WIDTH=8, OUT_W=8, seed 0x01, step_en=0, req with limit=3): valid 2 cycles after accept, rand_out=1, state_out=0x02 afterwards.
- Rejection (seed 0x03, limit=3): first candidate 3 rejected, then 0x06 gives cand 2. valid 3 cycles after accept, rand_out=2.
- Fallback (MAX_TRIES=1, seed 0x07, limit=5, mask 7): cand 7 rejected. rand_out=2, valid 2 cycles after accept.
- Edge limits:
  - seed_load with seed=0 gives state_out=SEED_DEFAULT.
  - limit=1 gives rand_out=0.
  - limit=0 gives rand_out = lfsr[7:0].
  - req held high gives back-to-back draws, one valid per draw.
- Reset asserted mid-DRAW: valid stays 0, ready=1, state_out=SEED_DEFAULT, and the next request completes normally.
